// File: rtl/seq_priority_encoder.sv
// Serialising priority encoder: emits the index of each set request bit, one per output handshake, lowest first
// (highest first with SEQ_PRIO_ENC_MSB_FIRST_EN); first index one cycle after accept, input stalled while scanning.
module seq_priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_REQ,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [IDX_W-1:0] OUT_IDX,
  output logic             OUT_LAST,
  output logic             ZERO_PULSE
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pending, pending_nxt;
  logic             zero_q, zero_nxt;
  logic [IDX_W-1:0] sel_idx;
  logic             one_left;

  // Picks the next index to emit from the bits still pending.
  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) r = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
`endif
    return r;
  endfunction

  assign sel_idx  = pick(pending);
  assign one_left = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pending <= '0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      zero_q  <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (IN_VALID) begin
          if (IN_REQ != '0) begin
            pending_nxt = IN_REQ;
            state_nxt   = SCAN;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (OUT_READY) begin
          pending_nxt = pending & ~(WIDTH'(1) << sel_idx);
          if (one_left) state_nxt = IDLE;
        end
      end
    endcase
  end

  assign IN_READY   = (state == IDLE);
  assign OUT_VALID  = (state == SCAN);
  assign OUT_IDX    = sel_idx;
  assign OUT_LAST   = (state == SCAN) && one_left;
  assign ZERO_PULSE = zero_q;

endmodule
